adder_acc_pipe: RTL and testbench

Parametrised, pipelined multi-operand adder with an optional running accumulator, valid/ready flow control, and registered sum, zero and overflow flags. It is the next generation of the fixed four-field adder. The operand count and widths become parameters, backpressure is added, and an accumulate mode lets successive beats sum into one total. It sits in datapath blocks that reduce packed operand vectors, such as checksum and statistics paths.

---
 rtl/adder_acc_pipe.sv | 109 ++++++++++
 tb/tb_adder_acc_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_acc_pipe.sv
// adder_acc_pipe: two-stage multi-operand adder with running accumulator and valid/ready flow.
// Define ADDER_ACC_SAT_EN to saturate sum and accumulator on overflow; default build wraps.
module adder_acc_pipe #(
   parameter int unsigned NUM_OPS = 4,
   parameter int unsigned OP_W    = 8,
   parameter int unsigned SUM_W   = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [NUM_OPS*OP_W-1:0] ops_i,
   input  logic                    cin_i,
   input  logic                    accum_i,
   input  logic                    clear_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [SUM_W-1:0]        sum_o,
   output logic                    sum_zero_o,
   output logic                    overflow_o
);

   localparam int unsigned TW = OP_W + $clog2(NUM_OPS + 1);
   localparam int unsigned RW = ((SUM_W > TW) ? SUM_W : TW) + 1;

   logic             s1_valid_q;
   logic [TW-1:0]    s1_tot_q;
   logic             s1_accum_q;
   logic [SUM_W-1:0] acc_q;
   logic             out_valid_q;
   logic [SUM_W-1:0] sum_q;
   logic             sum_zero_q;
   logic             overflow_q;

   logic [TW-1:0]    beat_tot;
   logic             s2_load;
   logic [SUM_W-1:0] base;
   logic [RW-1:0]    res;
   logic             ovf_d;
   logic [SUM_W-1:0] sum_d;

   always_comb begin
      beat_tot = TW'(cin_i);
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
         beat_tot = beat_tot + TW'(ops_i[k*OP_W +: OP_W]);
      end
   end

   // Clear overrides accumulate so a beat loading alongside clear starts a fresh total.
   always_comb begin
      s2_load = s1_valid_q && (!out_valid_q || out_ready_i);
      base    = (clear_i || !s1_accum_q) ? '0 : acc_q;
      res     = RW'(base) + RW'(s1_tot_q);
      ovf_d   = |res[RW-1:SUM_W];
`ifdef ADDER_ACC_SAT_EN
      sum_d   = ovf_d ? '1 : res[SUM_W-1:0];
`else
      sum_d   = res[SUM_W-1:0];
`endif
   end

   assign in_ready_o = !s1_valid_q || s2_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_tot_q   <= '0;
         s1_accum_q <= 1'b0;
      end else if (in_valid_i && in_ready_o) begin
         s1_valid_q <= 1'b1;
         s1_tot_q   <= beat_tot;
         s1_accum_q <= accum_i;
      end else if (s2_load) begin
         s1_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (s2_load) begin
         acc_q <= sum_d;
      end else if (clear_i) begin
         acc_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         sum_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (s2_load) begin
         out_valid_q <= 1'b1;
         sum_q       <= sum_d;
         sum_zero_q  <= (sum_d == '0);
         overflow_q  <= ovf_d;
      end else if (out_valid_q && out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid_o = out_valid_q;
   assign sum_o       = sum_q;
   assign sum_zero_o  = sum_zero_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_adder_acc_pipe.sv
// Scoreboard bench for adder_acc_pipe: directed plan cases then randomized beats with
// random backpressure, checked against an arithmetic model of the accumulator.
module tb_adder_acc_pipe;

   localparam int unsigned NUM_OPS = 4;
   localparam int unsigned OP_W    = 8;
   localparam int unsigned SUM_W   = 10;
   localparam int unsigned MAXV    = (1 << SUM_W) - 1;
`ifdef ADDER_ACC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [SUM_W-1:0] sum;
      logic             zero;
      logic             ovf;
   } exp_t;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_OPS*OP_W-1:0] ops;
   logic                    cin;
   logic                    accum;
   logic                    clear;
   logic                    out_valid;
   logic                    out_ready;
   logic [SUM_W-1:0]        sum;
   logic                    sum_zero;
   logic                    overflow;

   exp_t        q[$];
   int unsigned macc;
   int          vectors;
   int          miscompares;
   bit          rnd_or;

   adder_acc_pipe #(
      .NUM_OPS(NUM_OPS),
      .OP_W   (OP_W),
      .SUM_W  (SUM_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .ops_i      (ops),
      .cin_i      (cin),
      .accum_i    (accum),
      .clear_i    (clear),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .sum_o      (sum),
      .sum_zero_o (sum_zero),
      .overflow_o (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Reference: beat total is plain integer arithmetic; fresh beats ignore the running total.
   task automatic push_model(input logic [NUM_OPS*OP_W-1:0] o, input logic c, input logic a,
                             input bit fresh);
      int unsigned tot;
      int unsigned r;
      exp_t        e;
      tot = c;
      for (int k = 0; k < NUM_OPS; k++) tot += o[k*OP_W +: OP_W];
      r     = ((a && !fresh) ? macc : 0) + tot;
      e.ovf = (r > MAXV);
      if (e.ovf && SAT) e.sum = SUM_W'(MAXV);
      else              e.sum = SUM_W'(r % (MAXV + 1));
      e.zero = (e.sum == 0);
      macc   = e.sum;
      q.push_back(e);
   endtask

   task automatic send(input logic [NUM_OPS*OP_W-1:0] o, input logic c, input logic a,
                       input bit clr_load);
      int guard;
      bit done;
      guard    = 0;
      done     = 0;
      in_valid = 1'b1;
      ops      = o;
      cin      = c;
      accum    = a;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            push_model(o, c, a, clr_load);
            done = 1;
         end else if (++guard > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            done = 1;
         end
         step();
      end
      in_valid = 1'b0;
      if (clr_load) begin
         clear = 1'b1;
         step();
         clear = 1'b0;
      end
   endtask

   task automatic drain();
      int g;
      g         = 0;
      rnd_or    = 0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && g < 100) begin
         step();
         g++;
      end
      if (g >= 100) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
      end
   endtask

   task automatic idle_clear();
      drain();
      clear = 1'b1;
      step();
      clear = 1'b0;
      macc  = 0;
   endtask

   // Monitor: pops on every handshake and checks that a stalled result holds still.
   initial begin
      bit               prev_stall;
      logic [SUM_W-1:0] h_sum;
      logic             h_zero;
      logic             h_ovf;
      exp_t             e;
      prev_stall = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_sum", sum, h_sum);
               chk("hold_zero", sum_zero, h_zero);
               chk("hold_ovf", overflow, h_ovf);
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL extra_output: got sum 0x%0h, expected no result", sum);
               end else begin
                  e = q.pop_front();
                  chk("sum", sum, e.sum);
                  chk("sum_zero", sum_zero, e.zero);
                  chk("overflow", overflow, e.ovf);
               end
            end
            prev_stall = out_valid && !out_ready;
            h_sum      = sum;
            h_zero     = sum_zero;
            h_ovf      = overflow;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      macc        = 0;
      rnd_or      = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      ops         = '0;
      cin         = 1'b0;
      accum       = 1'b0;
      clear       = 1'b0;
      out_ready   = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_sum_zero", sum_zero, 0);
      chk("rst_overflow", overflow, 0);
      step();
      rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1);

      // Basic beat and two-cycle latency
      send({8'h40, 8'h30, 8'h20, 8'h10}, 1'b1, 1'b0, 0);
      chk("latency_early", out_valid, 0);
      step();
      chk("latency_valid", out_valid, 1);
      drain();

      // Overflow on accumulate
      send({4{8'hFF}}, 1'b1, 1'b0, 0);
      send({4{8'hFF}}, 1'b1, 1'b1, 0);
      drain();

      // Zero flag, then clear winning over accumulate on the S2 load cycle
      send('0, 1'b0, 1'b0, 0);
      send({8'h00, 8'h00, 8'h00, 8'h01}, 1'b0, 1'b1, 1);
      send({8'h00, 8'h00, 8'h00, 8'h05}, 1'b0, 1'b0, 0);
      send({8'h00, 8'h00, 8'h00, 8'h01}, 1'b0, 1'b1, 1);
      drain();

      // Backpressure: two beats buffered, then in_ready holds low until release
      idle_clear();
      out_ready = 1'b0;
      send('0, 1'b1, 1'b1, 0);
      send('0, 1'b1, 1'b1, 0);
      chk("stall_in_ready", in_ready, 0);
      fork
         begin
            for (int i = 0; i < 3; i++) send('0, 1'b1, 1'b1, 0);
         end
         begin
            repeat (4) begin
               @(negedge clk);
               chk("stall_in_ready_hold", in_ready, 0);
               @(posedge clk);
            end
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages full
      out_ready = 1'b0;
      send({8'h00, 8'h00, 8'h00, 8'h11}, 1'b0, 1'b0, 0);
      send({8'h00, 8'h00, 8'h00, 8'h22}, 1'b0, 1'b1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_sum_zero", sum_zero, 0);
      chk("mid_rst_overflow", overflow, 0);
      q.delete();
      macc = 0;
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send({8'h00, 8'h00, 8'h00, 8'h07}, 1'b0, 1'b1, 0);
      drain();

      // Randomized beats with random backpressure and occasional idle clears
      rnd_or = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 31) == 0) begin
            idle_clear();
            rnd_or = 1;
         end else if ($urandom_range(0, 3) == 0) begin
            step();
         end else begin
            send($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 0);
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
